// File: rtl/ram_load_ctrl_pkg.sv
// Shared definitions for the program-RAM load controller.
// State encodings and default bus widths.
package ram_load_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDOFF = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/ram_load_ctrl.sv
// Arbitrates the program RAM port between the CPU bus and a byte-stream loader.
// The loader fills RAM from address 0 while the CPU is halted, summing bytes mod 2^DATA_W.
module ram_load_ctrl
    import ram_load_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOAD_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ri,
    input  logic              cpu_ro,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_halt,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_sum,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ri,
    output logic              ram_ro,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_LEN - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       xfer;

    assign xfer = (state == ST_LOAD) && ld_valid;

    // Dropping prog_mode wins over reaching the last byte; the byte is still written.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:     state_nxt = prog_mode ? ST_HANDOFF : ST_RUN;
            ST_HANDOFF: state_nxt = prog_mode ? ST_LOAD : ST_RUN;
            ST_LOAD: begin
                if (!prog_mode)
                    state_nxt = ST_RUN;
                else if (xfer && ld_addr == LAST)
                    state_nxt = ST_DONE;
            end
            ST_DONE:    state_nxt = prog_mode ? ST_DONE : ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            ld_addr <= '0;
            ld_sum  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_HANDOFF) begin
                ld_addr <= '0;
                ld_sum  <= '0;
            end else if (xfer) begin
                ld_addr <= ld_addr + ADDR_W'(1);
                ld_sum  <= ld_sum + ld_data;
            end
        end
    end

    // Every output decodes from the state register, never from prog_mode.
    always_comb begin
        cpu_halt  = 1'b1;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        ram_addr  = ld_addr;
        ram_ri    = 1'b0;
        ram_ro    = 1'b0;
        ram_wdata = ld_data;
        unique case (state)
            ST_RUN: begin
                cpu_halt  = 1'b0;
                ram_addr  = cpu_addr;
                ram_ri    = cpu_ri;
                ram_ro    = cpu_ro;
                ram_wdata = cpu_data_i;
            end
            ST_HANDOFF: ;
            ST_LOAD: begin
                ld_ready = 1'b1;
                ram_ri   = ld_valid;
            end
            ST_DONE:    ld_done = 1'b1;
        endcase
    end

    assign cpu_data_o = (state == ST_RUN && cpu_ro) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Self-checking bench for ram_load_ctrl with a behavioural 16x8 RAM attached.
// Expected RAM image, address and checksum come from a simple session model.
module tb_ram_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_mode;
    logic [3:0] cpu_addr;
    logic       cpu_ri;
    logic       cpu_ro;
    logic [7:0] cpu_data_i;
    logic [7:0] cpu_data_o;
    logic       cpu_halt;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic [3:0] ld_addr;
    logic [7:0] ld_sum;
    logic [3:0] ram_addr;
    logic       ram_ri;
    logic       ram_ro;
    logic [7:0] ram_wdata;
    wire  [7:0] ram_rdata;

    logic [7:0] ram [16];
    logic [7:0] mdl [16];
    int         m_cnt;
    logic [7:0] m_sum;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_ri) ram[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_ro ? ram[ram_addr] : 8'hzz;

    ram_load_ctrl #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
        .cpu_addr(cpu_addr), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_halt(cpu_halt), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_addr(ld_addr),
        .ld_sum(ld_sum), .ram_addr(ram_addr), .ram_ri(ram_ri),
        .ram_ro(ram_ro), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        cpu_ri = 0; cpu_ro = 0; cpu_addr = 0; cpu_data_i = 0;
    endtask

    // Model of one loader session: bytes land at consecutive addresses.
    task automatic start_session();
        m_cnt = 0;
        m_sum = 0;
    endtask

    // Present one byte after a random gap; the transfer completes on the next edge.
    task automatic send_byte(input logic [7:0] d, input logic drop);
        int gap;
        gap = $urandom_range(0, 2);
        ld_valid = 0;
        repeat (gap) tick();
        ld_valid = 1;
        ld_data  = d;
        if (drop) prog_mode = 0;
        #1;
        total++;
        if (ld_ready !== 1'b1)
            $display("FAIL send_ready: ld_ready=%b required 1", ld_ready);
        else
            passed++;
        tick();
        mdl[m_cnt % 16] = d;
        m_cnt++;
        m_sum = m_sum + d;
        ld_valid = 0;
    endtask

    task automatic enter_load();
        prog_mode = 1;
        tick();
        tick();
        start_session();
    endtask

    task automatic test_reset();
        rst_n = 0; prog_mode = 0; ld_valid = 0; ld_data = 0;
        idle_cpu();
        tick(); tick();
        total += 5;
        if (cpu_halt !== 1'b0) $display("FAIL rst_halt: %b required 0", cpu_halt); else passed++;
        if (ld_ready !== 1'b0) $display("FAIL rst_ready: %b required 0", ld_ready); else passed++;
        if (ld_done !== 1'b0) $display("FAIL rst_done: %b required 0", ld_done); else passed++;
        if (ld_addr !== 4'd0) $display("FAIL rst_addr: %0d required 0", ld_addr); else passed++;
        if (ld_sum !== 8'd0) $display("FAIL rst_sum: %h required 00", ld_sum); else passed++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_run();
        int a;
        cpu_addr = 3; cpu_ri = 1; cpu_data_i = 8'hA5;
        tick();
        mdl[3] = 8'hA5;
        cpu_ri = 0; cpu_ro = 1;
        #1;
        total++;
        if (cpu_data_o !== 8'hA5) $display("FAIL run_read3: %h required a5", cpu_data_o); else passed++;
        cpu_ro = 0;
        #1;
        total++;
        if (cpu_data_o !== 8'h00) $display("FAIL run_noro: %h required 00", cpu_data_o); else passed++;
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 4'(i); cpu_ri = 1; cpu_data_i = 8'($urandom);
            mdl[i] = cpu_data_i;
            tick();
        end
        cpu_ri = 0; cpu_ro = 1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 15);
            cpu_addr = 4'(a);
            #1;
            total++;
            if (cpu_data_o !== mdl[a])
                $display("FAIL run_rand[%0d]: %h required %h", a, cpu_data_o, mdl[a]);
            else passed++;
        end
        idle_cpu();
        // A one-cycle prog_mode pulse halts for HANDOFF only, then returns to RUN.
        prog_mode = 1;
        tick();
        prog_mode = 0;
        total++;
        if (cpu_halt !== 1'b1) $display("FAIL pulse_halt: %b required 1", cpu_halt); else passed++;
        tick();
        total += 2;
        if (cpu_halt !== 1'b0) $display("FAIL pulse_back: %b required 0", cpu_halt); else passed++;
        if (ld_ready !== 1'b0) $display("FAIL pulse_ready: %b required 0", ld_ready); else passed++;
    endtask

    task automatic test_full_load();
        prog_mode = 1;
        #1;
        total++;
        if (cpu_halt !== 1'b0) $display("FAIL halt_early: %b required 0", cpu_halt); else passed++;
        tick();
        total += 2;
        if (cpu_halt !== 1'b1) $display("FAIL halt_p1: %b required 1", cpu_halt); else passed++;
        if (ld_ready !== 1'b0) $display("FAIL ready_p1: %b required 0", ld_ready); else passed++;
        tick();
        start_session();
        total++;
        if (ld_ready !== 1'b1) $display("FAIL ready_p2: %b required 1", ld_ready); else passed++;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0);
            if (i < 15) begin
                total++;
                if (ld_done !== 1'b0) $display("FAIL done_early[%0d]: %b required 0", i, ld_done);
                else passed++;
            end
        end
        total += 5;
        if (ld_done !== 1'b1) $display("FAIL full_done: %b required 1", ld_done); else passed++;
        if (ld_ready !== 1'b0) $display("FAIL full_ready: %b required 0", ld_ready); else passed++;
        if (ld_sum !== 8'h78) $display("FAIL full_sum: %h required 78", ld_sum); else passed++;
        if (ld_sum !== m_sum) $display("FAIL full_sum_mdl: %h required %h", ld_sum, m_sum); else passed++;
        if (ld_addr !== 4'(m_cnt % 16)) $display("FAIL full_addr: %0d required %0d", ld_addr, m_cnt % 16); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (ram[i] !== 8'h10 + 8'(i))
                $display("FAIL full_ram[%0d]: %h required %h", i, ram[i], 8'h10 + 8'(i));
            else passed++;
        end
        tick();
        total++;
        if (ld_done !== 1'b1) $display("FAIL done_hold: %b required 1", ld_done); else passed++;
        prog_mode = 0;
        tick();
        total++;
        if (cpu_halt !== 1'b0) $display("FAIL done_exit: %b required 0", cpu_halt); else passed++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) mdl[i] = ram[i];
        enter_load();
        for (int i = 0; i < 5; i++)
            send_byte(8'($urandom), i == 4);
        total += 3;
        if (cpu_halt !== 1'b0) $display("FAIL abort_halt: %b required 0", cpu_halt); else passed++;
        if (ld_addr !== 4'd5) $display("FAIL abort_addr: %0d required 5", ld_addr); else passed++;
        if (ld_sum !== m_sum) $display("FAIL abort_sum: %h required %h", ld_sum, m_sum); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (ram[i] !== mdl[i])
                $display("FAIL abort_ram[%0d]: %h required %h", i, ram[i], mdl[i]);
            else passed++;
        end
        enter_load();
        total += 3;
        if (ld_addr !== 4'd0) $display("FAIL reenter_addr: %0d required 0", ld_addr); else passed++;
        if (ld_sum !== 8'd0) $display("FAIL reenter_sum: %h required 00", ld_sum); else passed++;
        if (ld_ready !== 1'b1) $display("FAIL reenter_ready: %b required 1", ld_ready); else passed++;
        prog_mode = 0;
        tick();
    endtask

    task automatic test_cpu_blocked();
        logic [7:0] d;
        enter_load();
        d = 8'($urandom_range(0, 254));
        cpu_addr = 0; cpu_ri = 1; cpu_ro = 1; cpu_data_i = 8'hFF;
        send_byte(d, 1'b0);
        total++;
        if (cpu_data_o !== 8'h00) $display("FAIL block_data: %h required 00", cpu_data_o); else passed++;
        tick();
        total += 2;
        if (ram[0] !== d) $display("FAIL block_ram0: %h required %h", ram[0], d); else passed++;
        if (ld_addr !== 4'd1) $display("FAIL block_addr: %0d required 1", ld_addr); else passed++;
        idle_cpu();
        prog_mode = 0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        enter_load();
        for (int i = 0; i < 3; i++)
            send_byte(8'($urandom), 1'b0);
        rst_n = 0;
        tick();
        rst_n = 1;
        prog_mode = 0;
        total += 4;
        if (cpu_halt !== 1'b0) $display("FAIL mrst_halt: %b required 0", cpu_halt); else passed++;
        if (ld_addr !== 4'd0) $display("FAIL mrst_addr: %0d required 0", ld_addr); else passed++;
        if (ld_sum !== 8'd0) $display("FAIL mrst_sum: %h required 00", ld_sum); else passed++;
        if (ld_ready !== 1'b0) $display("FAIL mrst_ready: %b required 0", ld_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ram[i] !== mdl[i])
                $display("FAIL mrst_ram[%0d]: %h required %h", i, ram[i], mdl[i]);
            else passed++;
        end
        cpu_ro = 1; cpu_addr = 2;
        #1;
        total++;
        if (cpu_data_o !== mdl[2]) $display("FAIL mrst_read: %h required %h", cpu_data_o, mdl[2]); else passed++;
        idle_cpu();
        tick();
    endtask

    initial begin
        test_reset();
        test_run();
        test_full_load();
        test_abort();
        test_cpu_blocked();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
